// File: rtl/rr_onehot_arbiter_if.sv
//==============================================================================
// Module      : rr_onehot_arbiter_if
// Description : Request/grant bundle for the 8-way round-robin arbiter.
//               Optional macro RR_ARB_MASK_EN adds the req_mask signal.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rr_onehot_arbiter_if;
  logic [7:0] req;
`ifdef RR_ARB_MASK_EN
  logic [7:0] req_mask;
`endif
  logic [7:0] gnt;
  logic [2:0] gnt_code;
  logic       gnt_valid;
  logic       hold_expired;

  // Requester side: drives requests, observes grants.
  modport master (
    output req,
`ifdef RR_ARB_MASK_EN
    output req_mask,
`endif
    input  gnt,
    input  gnt_code,
    input  gnt_valid,
    input  hold_expired
  );

  // Arbiter side: observes requests, drives grants.
  modport slave (
    input  req,
`ifdef RR_ARB_MASK_EN
    input  req_mask,
`endif
    output gnt,
    output gnt_code,
    output gnt_valid,
    output hold_expired
  );
endinterface

`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
//==============================================================================
// Module      : rr_onehot_arbiter
// Description : 8-way round-robin arbiter with registered one-hot grant,
//               binary grant code, hold-time limit and a mandatory dead cycle
//               between grants. Optional macro RR_ARB_MASK_EN enables the
//               per-requester req_mask input.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_onehot_arbiter #(
  parameter int unsigned MAX_HOLD = 16,  // 0 = unlimited ownership
  parameter int unsigned HOLD_W   = 16   // 2**HOLD_W must exceed MAX_HOLD
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  rr_onehot_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);
  localparam bit                c_limited  = (MAX_HOLD != 0);

  state_t              r_state;
  logic [2:0]          r_ptr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [7:0]          r_gnt;
  logic [2:0]          r_code;
  logic                r_valid;
  logic                r_expired;

  state_t              w_state_nxt;
  logic [2:0]          w_ptr_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [7:0]          w_gnt_nxt;
  logic [2:0]          w_code_nxt;
  logic                w_valid_nxt;
  logic                w_expired_nxt;

  logic [7:0]          w_req_eff;
  logic                w_found;
  logic [2:0]          w_winner;
  logic                w_rel_a;
  logic                w_rel_b;

`ifdef RR_ARB_MASK_EN
  assign w_req_eff = bus.req & bus.req_mask;
`else
  assign w_req_eff = bus.req;
`endif

  // Owner dropped its (enabled) request, or used up its hold allowance.
  assign w_rel_a = ~w_req_eff[r_code];
  assign w_rel_b = c_limited && (r_hold_cnt == c_max_hold);

  // Rotating priority search: ptr+1 first, wrapping, ptr itself last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int i = 1; i <= 8; i++) begin
      if (!w_found && w_req_eff[3'(r_ptr + 3'(i))]) begin
        w_found  = 1'b1;
        w_winner = 3'(r_ptr + 3'(i));
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_code_nxt    = r_code;
    w_valid_nxt   = r_valid;
    w_expired_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 8'(1) << w_winner;
          w_code_nxt  = w_winner;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = HOLD_W'(1);
        end
      end
      S_GRANT: begin
        if (w_rel_a || w_rel_b) begin
          // Break before make: always pass through IDLE with gnt low.
          w_state_nxt   = S_IDLE;
          w_gnt_nxt     = 8'h00;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = r_code;
          // A voluntary release in the last allowed cycle is not a timeout.
          w_expired_nxt = w_rel_b && !w_rel_a;
        end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the grant without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd7;
      r_hold_cnt <= '0;
      r_gnt      <= 8'h00;
      r_code     <= 3'd0;
      r_valid    <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_code     <= w_code_nxt;
      r_valid    <= w_valid_nxt;
      r_expired  <= w_expired_nxt;
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.gnt_code     = r_code;
  assign bus.gnt_valid    = r_valid;
  assign bus.hold_expired = r_expired;

endmodule

`default_nettype wire

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- 8-way round-robin arbiter that shares one resource among requesters 0..7.
- Issues a registered one-hot grant vector plus its matching 3-bit binary code, with the same code-to-one-hot mapping as the team's 3-to-8 decoder (code k -> bit k).
- A grant is held while its owner keeps requesting, up to a configurable time limit.
- There is always one dead cycle between consecutive grants (break-before-make).

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership. 0 = unlimited. Legal range 0..65535.
- HOLD_W, 16, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit k = requester k. Level-sensitive.
- gnt  output  8  one-hot grant, registered. All-zero when no grant is active.
- gnt_code  output  3  binary index of the current owner. Valid only when gnt_valid=1; otherwise holds the last owner.
- gnt_valid  output  1  high whenever gnt is non-zero.
- hold_expired  output  1  one-cycle pulse, coincident with the first dead cycle after a grant ended by the MAX_HOLD timeout.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - gnt=8'h00, gnt_code=3'd0, gnt_valid=0, hold_expired=0.
  - Internal state: state=IDLE, ptr=3'd7 (so requester 0 has top priority first), hold_cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - Search req starting at index ptr+1, then ptr+2, wrapping mod 8; the first set bit wins.
  - If a winner exists, at the next edge: state=GRANT, gnt=1<<winner, gnt_code=winner, gnt_valid=1, hold_cnt=1.
  - If req=0, stay in IDLE; outputs stay zero.
  - Latency: req asserted in cycle n (state IDLE) -> gnt visible in cycle n+1.
- GRANT:
  - Release conditions: (a) req[gnt_code]=0, or (b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
  - On release, at the next edge: gnt=0, gnt_valid=0, state=IDLE, ptr=gnt_code.
  - If the release is by (b) and not (a), hold_expired=1 for that single cycle.
  - Otherwise hold_cnt increments (saturating at all-ones when MAX_HOLD=0).
  - Requests from other requesters are ignored while in GRANT; there is no preemption.
- Boundary rules:
  - Minimum grant length is 1 cycle (owner req pulsed for one cycle).
  - Maximum grant length is MAX_HOLD cycles. The next grant appears no earlier than 1 dead cycle after release.
  - When (a) and (b) occur together, the release is treated as (a): hold_expired stays 0.
  - A sole requester that timed out is re-granted after the dead cycle. Timeout lowers priority; it never blocks.
  - ptr=7 wrap: the search order is 0,1,...,7.
  - gnt is always one-hot or zero; never multi-hot.
  - rst_n low mid-grant drops gnt immediately (asynchronously) and restores all reset values.
  - The first arbitration after reset deassertion happens at the first clk edge with rst_n high.

Optional Feature:
- Macro: RR_ARB_MASK_EN.
- Defined:
  - Adds input port req_mask (8 bits; 1 = enabled). Arbitration in IDLE uses req & req_mask.
  - In GRANT, req_mask[gnt_code]=0 is treated as release condition (a).
  - A masked requester never wins, even if it is the only requester.
- Undefined:
  - The port does not exist; all requesters are always enabled. Behaviour is identical to the mask being tied to 8'hFF.

Test Plan:
- Reset then single request: rst_n released, req=8'h04 held for 3 cycles then 0 -> gnt=8'h04, gnt_code=2, gnt_valid=1 starting the cycle after req rises, lasting 3 cycles; gnt=0 the cycle after req falls; ptr=2.
- Round-robin fairness: after the first grant to requester 0, req=8'hFF with each owner dropping req 2 cycles after its grant -> grant sequence 1,2,3,...,7,0 with one dead cycle between grants.
- Wrap from ptr=7: last owner 7, then req=8'h81 -> requester 0 granted first, then 7 on the next arbitration.
- Timeout (MAX_HOLD=4): req=8'h03 held continuously -> gnt0 high for exactly 4 cycles, dead cycle with hold_expired=1, then gnt1 for 4 cycles, then gnt0.
- Sole timeout and simultaneous release (MAX_HOLD=4): only req0 held -> gnt0 re-granted after each single dead cycle. Separately, req0 dropped in the 4th grant cycle -> release with hold_expired=0.
- Reset mid-grant and mask (RR_ARB_MASK_EN defined): assert rst_n=0 during gnt=8'h10 -> gnt=0 without waiting for a clock edge. With req=8'h30 and req_mask=8'hEF -> gnt=8'h20 only; clearing req_mask[5] during that grant -> release on the next edge.
